// File: rtl/imm_compress.sv
// ---------------------------------------------------------------------------
// imm_compress
//
// Streaming 32-bit to 16-bit immediate compressor. Each accepted word leaves
// as a single halfword when sign-extending that halfword rebuilds the word
// ("short"). Otherwise it leaves as two halfwords, upper half first. This is
// the encoding side of the 16->32 sign-extension unit. Two usage counters
// track accepted words and accepted short words.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   in_data is valid
//   in_ready   out  1   word accepted this cycle when in_valid is also high
//                       (combinational from out_ready)
//   in_data    in  32   word to compress
//   out_valid  out  1   halfword beat is valid (registered)
//   out_ready  in   1   downstream accepts the beat
//   out_data   out 16   halfword payload (registered)
//   out_short  out  1   1 = whole word in this beat, sign-extend to recover
//   out_last   out  1   final beat of the current word
//   cnt_words  out 16   accepted words, wraps modulo 2^16
//   cnt_short  out 16   accepted short words, wraps modulo 2^16
// ---------------------------------------------------------------------------
module imm_compress (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_short,
  output logic        out_last,
  output logic [15:0] cnt_words,
  output logic [15:0] cnt_short
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    HI    = 2'd2,
    LO    = 2'd3
  } stateT;

  stateT       stateReg;
  stateT       stateNext;

  logic [15:0] loHoldReg;
  logic [15:0] outDataReg;
  logic [15:0] outDataNext;
  logic        outShortReg;
  logic        outShortNext;
  logic        outLastReg;
  logic        outLastNext;
  logic        outValidReg;
  logic        outValidNext;
  logic [15:0] cntWordsReg;
  logic [15:0] cntShortReg;

  logic [15:0] bitMatch;
  logic        wordIsShort;
  logic        inFire;
  logic        finalBeat;
  stateT       firstState;

  // A word is short when bits 31:16 all repeat bit 15, so the low
  // halfword already holds the full value in sign-extended form.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : gShortTest
      assign bitMatch[gi] = in_data[16 + gi] ~^ in_data[15];
    end
  endgenerate

  assign wordIsShort = &bitMatch;

  // The last beat of a word may hand over to the next word in the same
  // cycle. That keeps short words at one per cycle. It also makes in_ready
  // depend combinationally on out_ready.
  assign finalBeat  = (stateReg == SHORT) || (stateReg == LO);
  assign in_ready   = (stateReg == IDLE) || (out_ready && finalBeat);
  assign inFire     = in_valid && in_ready;
  assign firstState = wordIsShort ? SHORT : HI;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= IDLE;
      outValidReg <= 1'b0;
      outDataReg  <= 16'h0000;
      outShortReg <= 1'b0;
      outLastReg  <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      outValidReg <= outValidNext;
      outDataReg  <= outDataNext;
      outShortReg <= outShortNext;
      outLastReg  <= outLastNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (inFire) begin
          stateNext = firstState;
        end
      end
      HI: begin
        if (out_ready) begin
          stateNext = LO;
        end
      end
      SHORT, LO: begin
        if (out_ready) begin
          stateNext = inFire ? firstState : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next output values. With no accept and no handshake, every field holds.
  // That holds the beat stable under backpressure.
  // ---------------------------------------------------------------------------
  always_comb begin
    outValidNext = (stateNext != IDLE);
    outDataNext  = outDataReg;
    outShortNext = outShortReg;
    outLastNext  = outLastReg;

    if (inFire) begin
      outDataNext  = wordIsShort ? in_data[15:0] : in_data[31:16];
      outShortNext = wordIsShort;
      outLastNext  = wordIsShort;
    end else if ((stateReg == HI) && out_ready) begin
      outDataNext  = loHoldReg;
      outShortNext = 1'b0;
      outLastNext  = 1'b1;
    end else if (stateNext == IDLE) begin
      // Return to a clean idle bus so stale payload is never visible.
      outDataNext  = 16'h0000;
      outShortNext = 1'b0;
      outLastNext  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Lower-half holding register. It is loaded at accept, so the upstream
  // may change in_data while the upper half is still being sent.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loHoldReg <= 16'h0000;
    end else if (inFire) begin
      loHoldReg <= in_data[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Usage counters. They wrap naturally at 16 bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntWordsReg <= 16'h0000;
      cntShortReg <= 16'h0000;
    end else if (inFire) begin
      cntWordsReg <= cntWordsReg + 16'd1;
      if (wordIsShort) begin
        cntShortReg <= cntShortReg + 16'd1;
      end
    end
  end

  assign out_valid = outValidReg;
  assign out_data  = outDataReg;
  assign out_short = outShortReg;
  assign out_last  = outLastReg;
  assign cnt_words = cntWordsReg;
  assign cnt_short = cntShortReg;

endmodule
